// File: rtl/mul_sweep_pkg.sv
// Shared types and width helpers for the multiplier error sweep.
// FSM state enum plus product/count/sum width functions.
package mul_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic int pw(input int w);
    return 2 * w;
  endfunction

  function automatic int cw(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int sw(input int w);
    return 4 * w;
  endfunction

endpackage

// File: rtl/mul_err_sweep_if.sv
// Bus between the sweep stage and the multiplier under test.
// master: drives operands/enable; slave: returns product/overflow.
interface mul_err_sweep_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0]   mul_in1;
  logic [WIDTH-1:0]   mul_in2;
  logic               mul_en;
  logic [2*WIDTH-1:0] mul_out;
  logic               mul_ovf;

  modport master (
    output mul_in1, mul_in2, mul_en,
    input  mul_out, mul_ovf
  );

  modport slave (
    input  mul_in1, mul_in2, mul_en,
    output mul_out, mul_ovf
  );
endinterface

// File: rtl/mul_exp_pipe.sv
// LAT-deep delay line of {valid, exact product, in1, in2}.
// Ports: clk, rst_n, en, in_* (from operands), out_* (to compare).
module mul_exp_pipe #(
  parameter int W   = 6,
  parameter int LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_v,
  input  logic [2*W-1:0] in_p,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_v,
  output logic [2*W-1:0] out_p,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b
);
  localparam int EW = 1 + 4 * W;

  generate
    if (LAT == 0) begin : g_thru
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n, en};
      assign out_v = in_v;
      assign out_p = in_p;
      assign out_a = in_a;
      assign out_b = in_b;
    end else begin : g_sr
      logic [EW-1:0] sr [LAT];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++)
            sr[i] <= '0;
        end else if (en) begin
          sr[0] <= {in_v, in_p, in_a, in_b};
          for (int i = 1; i < LAT; i++)
            sr[i] <= sr[i-1];
        end
      end
      assign {out_v, out_p, out_a, out_b} = sr[LAT-1];
    end
  endgenerate
endmodule

// File: rtl/mul_err_sweep.sv
// Exhaustive operand sweep and error statistics for a multiplier.
// Ports: clk, rst_n, start, stall, mul bus, busy/done, statistics.
module mul_err_sweep
  import mul_sweep_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int LAT   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stall,
  mul_err_sweep_if.master        mul,
  output logic                   busy,
  output logic                   done,
  output logic [cw(WIDTH)-1:0]   err_cnt,
  output logic [sw(WIDTH)-1:0]   sed,
  output logic [pw(WIDTH)-1:0]   max_ed,
  output logic [cw(WIDTH)-1:0]   ovf_cnt,
  output logic [WIDTH-1:0]       first_err_in1,
  output logic [WIDTH-1:0]       first_err_in2
);
  localparam int PW = pw(WIDTH);
  localparam int CW = cw(WIDTH);
  localparam int SW = sw(WIDTH);

  state_t state, state_n;
  logic [PW-1:0] k;
  logic [2:0]    dcnt;
  logic          en, last, go, seen;
  logic [PW-1:0] exact, pp, ed;
  logic [WIDTH-1:0] pa, pb;
  logic          pv, cmp, mis;

  assign busy  = (state == RUN) || (state == DRAIN);
  assign done  = (state == DONE);
  assign en    = busy & ~stall;
  assign last  = &k;
  assign go    = start & ((state == IDLE) || (state == DONE));

  assign mul.mul_en  = en;
  assign mul.mul_in1 = k[PW-1:WIDTH];
  assign mul.mul_in2 = k[WIDTH-1:0];

  assign exact = {{WIDTH{1'b0}}, mul.mul_in1}
               * {{WIDTH{1'b0}}, mul.mul_in2};

  mul_exp_pipe #(.W(WIDTH), .LAT(LAT)) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in_v  (state == RUN),
    .in_p  (exact),
    .in_a  (mul.mul_in1),
    .in_b  (mul.mul_in2),
    .out_v (pv),
    .out_p (pp),
    .out_a (pa),
    .out_b (pb)
  );

  // gate with en so a stalled cycle is never counted twice
  assign cmp = pv & en;
  assign mis = (mul.mul_out != pp);
  assign ed  = (mul.mul_out >= pp) ? mul.mul_out - pp
                                   : pp - mul.mul_out;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = RUN;
      RUN:   if (!stall && last)
               state_n = (LAT == 0) ? DONE : DRAIN;
      DRAIN: if (!stall && dcnt == 3'd1) state_n = DONE;
      DONE:  if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k    <= '0;
      dcnt <= '0;
    end else begin
      if (go)
        k <= '0;
      else if (state == RUN && !stall && !last)
        k <= k + PW'(1);
      if (state == RUN && !stall && last)
        dcnt <= 3'(LAT);
      else if (state == DRAIN && !stall)
        dcnt <= dcnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || go) begin
      err_cnt       <= '0;
      sed           <= '0;
      max_ed        <= '0;
      ovf_cnt       <= '0;
      first_err_in1 <= '0;
      first_err_in2 <= '0;
      seen          <= 1'b0;
    end else if (cmp) begin
      if (mis) begin
        err_cnt <= err_cnt + CW'(1);
        if (!seen) begin
          seen          <= 1'b1;
          first_err_in1 <= pa;
          first_err_in2 <= pb;
        end
      end
      sed <= sed + SW'(ed);
      if (ed > max_ed) max_ed <= ed;
      if (mul.mul_ovf) ovf_cnt <= ovf_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_mul_err_sweep.sv
// Self-checking bench for mul_err_sweep (LAT=0 and LAT=2 instances).
// Reference stats come from plain loops over all operand pairs.
module tb_mul_err_sweep;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n, start0, start1, stall0, stall1;
  int   mode;
  int   off_tab [4096];
  bit   ovf_tab [4096];
  int   total = 0;
  int   bad   = 0;
  int   e_err, e_sed, e_max, e_ovf, e_fa, e_fb;
  int   dc;

  logic busy0, done0, busy1, done1;
  logic [12:0] err0, ovf0, err1, ovf1;
  logic [23:0] sed0, sed1;
  logic [11:0] max0, max1;
  logic [5:0]  fa0, fb0, fa1, fb1;
  logic [11:0] p1, p2;

  mul_err_sweep_if #(.WIDTH(6)) bus0 ();
  mul_err_sweep_if #(.WIDTH(6)) bus1 ();

  mul_err_sweep #(.WIDTH(6), .LAT(0)) u0 (
    .clk(clk), .rst_n(rst0_n), .start(start0), .stall(stall0),
    .mul(bus0), .busy(busy0), .done(done0),
    .err_cnt(err0), .sed(sed0), .max_ed(max0), .ovf_cnt(ovf0),
    .first_err_in1(fa0), .first_err_in2(fb0)
  );

  mul_err_sweep #(.WIDTH(6), .LAT(2)) u1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .stall(stall1),
    .mul(bus1), .busy(busy1), .done(done1),
    .err_cnt(err1), .sed(sed1), .max_ed(max1), .ovf_cnt(ovf1),
    .first_err_in1(fa1), .first_err_in2(fb1)
  );

  function automatic logic [11:0] model(input int md, input int a, input int b);
    int p;
    p = a * b;
    case (md)
      1: if (a == 63 && b == 63) p = p + 1;
      2: p = p ^ 1;
      3: if (p + off_tab[a*64+b] >= 0) p = p + off_tab[a*64+b];
      default: ;
    endcase
    return 12'(p);
  endfunction

  function automatic bit ovf_of(input int md, input int a, input int b);
    return (md == 3) ? ovf_tab[a*64+b] : 1'b0;
  endfunction

  always_comb begin
    bus0.mul_out = model(mode, int'(bus0.mul_in1), int'(bus0.mul_in2));
    bus0.mul_ovf = ovf_of(mode, int'(bus0.mul_in1), int'(bus0.mul_in2));
  end

  // two-stage pipelined exact multiplier, advanced by mul_en
  always @(posedge clk) begin
    if (bus1.mul_en) begin
      p1 <= 12'(bus1.mul_in1) * 12'(bus1.mul_in2);
      p2 <= p1;
    end
  end
  assign bus1.mul_out = p2;
  assign bus1.mul_ovf = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ref_stats(input int md, input bit ovf_all);
    int m, e, d;
    bit seen;
    e_err = 0; e_sed = 0; e_max = 0; e_ovf = 0;
    e_fa = 0; e_fb = 0; seen = 0;
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        e = a * b;
        m = int'(model(md, a, b));
        if (m != e) begin
          e_err++;
          if (!seen) begin seen = 1; e_fa = a; e_fb = b; end
        end
        d = (m > e) ? m - e : e - m;
        e_sed += d;
        if (d > e_max) e_max = d;
        if (ovf_all || ovf_of(md, a, b)) e_ovf++;
      end
    end
  endtask

  task automatic check_stats(input int inst, input string t);
    if (inst == 0) begin
      chk({t, "_err"}, err0, e_err);
      chk({t, "_sed"}, sed0, e_sed);
      chk({t, "_max"}, max0, e_max);
      chk({t, "_ovf"}, ovf0, e_ovf);
      chk({t, "_fa"}, fa0, e_fa);
      chk({t, "_fb"}, fb0, e_fb);
      chk({t, "_busy"}, busy0, 0);
    end else begin
      chk({t, "_err"}, err1, e_err);
      chk({t, "_sed"}, sed1, e_sed);
      chk({t, "_max"}, max1, e_max);
      chk({t, "_ovf"}, ovf1, e_ovf);
      chk({t, "_fa"}, fa1, e_fa);
      chk({t, "_fb"}, fb1, e_fb);
      chk({t, "_busy"}, busy1, 0);
    end
  endtask

  task automatic check_reset0(input string t);
    chk({t, "_busy"}, busy0, 0);
    chk({t, "_done"}, done0, 0);
    chk({t, "_err"}, err0, 0);
    chk({t, "_sed"}, sed0, 0);
    chk({t, "_max"}, max0, 0);
    chk({t, "_ovf"}, ovf0, 0);
    chk({t, "_fe"}, {fa0, fb0}, 0);
    chk({t, "_in"}, {bus0.mul_in1, bus0.mul_in2}, 0);
    chk({t, "_en"}, bus0.mul_en, 0);
  endtask

  // cycle numbering: start is sampled at the end of cycle 0
  task automatic run(input int inst, input int stall_at, input int stall_len,
                     input int rst_at, input int bogus_at, output int dcyc);
    int cnt;
    dcyc = -1;
    @(negedge clk);
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    cnt = 1;
    while (!(inst == 1 ? done1 : done0) && cnt < 6000) begin
      if (cnt == stall_at) begin
        stall0 = 1'b1; #1;
        chk("stall_en", bus0.mul_en, 0);
        chk("stall_hold", {bus0.mul_in1, bus0.mul_in2}, stall_at - 1);
      end
      if (cnt == stall_at + stall_len) stall0 = 1'b0;
      if (cnt == bogus_at) begin
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        cnt++;
        chk("ign_start", {bus0.mul_in1, bus0.mul_in2}, cnt - 1);
        chk("ign_busy", busy0, 1);
      end else if (cnt == rst_at) begin
        rst0_n = 1'b0;
        @(posedge clk); #1;
        rst0_n = 1'b1;
        check_reset0("midrst");
        return;
      end else begin
        @(posedge clk); #1;
        cnt++;
      end
    end
    if (inst == 1 ? done1 : done0) dcyc = cnt;
  endtask

  initial begin
    mode = 0;
    start0 = 0; start1 = 0; stall0 = 0; stall1 = 0;
    p1 = '0; p2 = '0;
    for (int i = 0; i < 4096; i++) begin
      off_tab[i] = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(0, 80)) - 40 : 0;
      ovf_tab[i] = 1'($urandom_range(0, 1));
    end
    rst0_n = 0; rst1_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset0("rst");
    chk("rst1_done", done1, 0);
    chk("rst1_busy", busy1, 0);
    rst0_n = 1; rst1_n = 1;

    run(0, -1, 0, -1, -1, dc);
    chk("t1_done_cyc", dc, 4097);
    ref_stats(0, 0);
    check_stats(0, "t1");

    mode = 1;
    run(0, -1, 0, -1, -1, dc);
    chk("t2_done_cyc", dc, 4097);
    ref_stats(1, 0);
    check_stats(0, "t2");

    mode = 2;
    run(0, -1, 0, -1, -1, dc);
    chk("t3_done_cyc", dc, 4097);
    ref_stats(2, 0);
    check_stats(0, "t3");

    mode = 3;
    run(0, -1, 0, -1, -1, dc);
    chk("trnd_done_cyc", dc, 4097);
    ref_stats(3, 0);
    check_stats(0, "trnd");

    run(1, -1, 0, -1, -1, dc);
    chk("t4_done_cyc", dc, 4099);
    ref_stats(0, 1);
    check_stats(1, "t4");

    mode = 0;
    run(0, 101, 10, -1, -1, dc);
    chk("t5_done_cyc", dc, 4107);
    ref_stats(0, 0);
    check_stats(0, "t5");

    run(0, -1, 0, 2001, 500, dc);
    chk("t6_abort", dc, -1);
    run(0, -1, 0, -1, -1, dc);
    chk("t6_done_cyc", dc, 4097);
    check_stats(0, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
